maze_mem_arbiter: RTL and testbench

Owns the 16x16 single-bit maze map memory and shares its single port between two requesters: the mouse controller (wall reads, visited-mark writes during exploration) and the host loader (map load and readback). Performs one access per cycle with round-robin fairness, a bounded host burst lock, and a self-timed clear sequence. Sits between the mouse top level's RD/WR/Dout/Din interface and the map storage.

---
 rtl/maze_mem_if.sv | 51 +++++
 rtl/maze_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_maze_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_mem_if.sv
// Request/grant bus between the mouse and host requesters and the maze map arbiter.
// Both requesters share the same handshake; only the host has a lock input.
//
// Handshake: a requester raises xx_req together with xx_we/xx_x/xx_y/xx_wdata and
// holds all of them stable until a cycle in which xx_gnt is high; that cycle
// performs the access. Holding xx_req high after the grant cycle requests a new
// access. Read data appears on xx_rdata with a one-cycle xx_valid pulse in the
// cycle after the read grant. busy is high while a clear sequence owns the map.
interface maze_mem_if #(
  parameter int COORD_W = 4
) ();
  logic               m_req;
  logic               m_we;
  logic [COORD_W-1:0] m_x;
  logic [COORD_W-1:0] m_y;
  logic               m_wdata;
  logic               m_gnt;
  logic               m_rdata;
  logic               m_valid;

  logic               h_req;
  logic               h_we;
  logic [COORD_W-1:0] h_x;
  logic [COORD_W-1:0] h_y;
  logic               h_wdata;
  logic               h_lock;
  logic               h_gnt;
  logic               h_rdata;
  logic               h_valid;

  logic               clr;
  logic               busy;

  modport slave (
    input  m_req, m_we, m_x, m_y, m_wdata,
    input  h_req, h_we, h_x, h_y, h_wdata, h_lock,
    input  clr,
    output m_gnt, m_rdata, m_valid,
    output h_gnt, h_rdata, h_valid,
    output busy
  );

  modport master (
    output m_req, m_we, m_x, m_y, m_wdata,
    output h_req, h_we, h_x, h_y, h_wdata, h_lock,
    output clr,
    input  m_gnt, m_rdata, m_valid,
    input  h_gnt, h_rdata, h_valid,
    input  busy
  );
endinterface

// File: rtl/maze_mem_arbiter.sv
// Single-port 2^(2*COORD_W)-bit maze map shared by mouse and host, one access per
// cycle, round-robin with a bounded host burst lock and a self-timed clear sweep.
module maze_mem_arbiter #(
  parameter int   COORD_W   = 4,
  parameter int   MAX_BURST = 4,
  parameter logic CLR_VALUE = 1'b0
) (
  input  logic      CLK,
  input  logic      RST,
  maze_mem_if.slave bus,
  output logic      state_dbg
);

  localparam int ADDR_W = 2 * COORD_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic { ARB = 1'b0, CLEAR = 1'b1 } state_t;
  typedef enum logic { MOUSE = 1'b0, HOST = 1'b1 } owner_t;

  state_t              state;
  owner_t              last_grant;
  logic [BCNT_W-1:0]   burst_cnt;
  logic [ADDR_W-1:0]   clr_cnt;

  logic                mem [DEPTH];

  logic [ADDR_W-1:0]   m_addr;
  logic [ADDR_W-1:0]   h_addr;
  logic                m_gnt_c;
  logic                h_gnt_c;
  logic                host_locked;
  logic                clear_we;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wdata;

  assign m_addr = {bus.m_y, bus.m_x};
  assign h_addr = {bus.h_y, bus.h_x};

  // The lock only matters under contention; burst_cnt bounds how long the mouse waits.
  assign host_locked = bus.h_lock && (last_grant == HOST) &&
                       (burst_cnt < BCNT_W'(MAX_BURST));

  always_comb begin
    m_gnt_c = 1'b0;
    h_gnt_c = 1'b0;
    if (!RST && state == ARB && !bus.clr) begin
      if (bus.m_req && bus.h_req) begin
        if (host_locked) begin
          h_gnt_c = 1'b1;
        end else if (last_grant == HOST) begin
          m_gnt_c = 1'b1;
        end else begin
          h_gnt_c = 1'b1;
        end
      end else begin
        m_gnt_c = bus.m_req;
        h_gnt_c = bus.h_req;
      end
    end
  end

  assign bus.m_gnt = m_gnt_c;
  assign bus.h_gnt = h_gnt_c;
  assign bus.busy  = (state == CLEAR);
  assign state_dbg = logic'(state);

  // A reset cycle never writes, so a sweep interrupted by reset stops exactly where it was.
  assign clear_we = (state == CLEAR) && !RST;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = m_addr;
    mem_wdata = bus.m_wdata;
    if (clear_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = CLR_VALUE;
    end else if (m_gnt_c && bus.m_we) begin
      mem_we    = 1'b1;
    end else if (h_gnt_c && bus.h_we) begin
      mem_we    = 1'b1;
      mem_addr  = h_addr;
      mem_wdata = bus.h_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ARB;
      last_grant  <= HOST;
      burst_cnt   <= '0;
      clr_cnt     <= '0;
      bus.m_valid <= 1'b0;
      bus.h_valid <= 1'b0;
      bus.m_rdata <= 1'b0;
      bus.h_rdata <= 1'b0;
    end else begin
      bus.m_valid <= m_gnt_c && !bus.m_we;
      bus.h_valid <= h_gnt_c && !bus.h_we;
      if (m_gnt_c && !bus.m_we) begin
        bus.m_rdata <= mem[m_addr];
      end
      if (h_gnt_c && !bus.h_we) begin
        bus.h_rdata <= mem[h_addr];
      end

      if (m_gnt_c) begin
        last_grant <= MOUSE;
      end else if (h_gnt_c) begin
        last_grant <= HOST;
      end

      if (!bus.h_lock || m_gnt_c) begin
        burst_cnt <= '0;
      end else if (h_gnt_c && bus.m_req && burst_cnt < BCNT_W'(MAX_BURST)) begin
        burst_cnt <= burst_cnt + 1'b1;
      end

      case (state)
        ARB: begin
          if (bus.clr) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: directed vector table, clear/reset sequences and a
// randomized phase, all checked against a rule-level model of the arbiter and map.
module tb_maze_mem_arbiter;
  localparam int   COORD_W   = 4;
  localparam int   MAX_BURST = 4;
  localparam int   DEPTH     = 256;
  localparam logic CLR_VALUE = 1'b0;

  logic CLK;
  logic RST;
  logic state_dbg;

  maze_mem_if #(.COORD_W(COORD_W)) bus ();

  maze_mem_arbiter #(
    .COORD_W  (COORD_W),
    .MAX_BURST(MAX_BURST),
    .CLR_VALUE(CLR_VALUE)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;

  bit         model_mem [DEPTH];
  bit         last_host;
  int         burst;
  int         clear_pos;
  bit         exp_mv, exp_hv;
  logic [0:0] m_exp_q[$];
  logic [0:0] h_exp_q[$];
  bit         g_m, g_h, g_busy;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_host = 1'b1;
    burst     = 0;
    clear_pos = -1;
    exp_mv    = 1'b0;
    exp_hv    = 1'b0;
    m_exp_q.delete();
    h_exp_q.delete();
  endtask

  // One clock cycle: check grants/busy mid-cycle, advance the model, check read outputs after the edge.
  task automatic tick();
    bit em, eh, busy_e;
    @(negedge CLK);
    em = 1'b0;
    eh = 1'b0;
    busy_e = (clear_pos >= 0);
    if (!busy_e && !bus.clr) begin
      if (bus.m_req && bus.h_req) begin
        if (bus.h_lock && last_host && burst < MAX_BURST) eh = 1'b1;
        else if (last_host) em = 1'b1;
        else eh = 1'b1;
      end else begin
        em = bus.m_req;
        eh = bus.h_req;
      end
    end
    g_m    = bus.m_gnt;
    g_h    = bus.h_gnt;
    g_busy = bus.busy;
    chk("m_gnt", int'(bus.m_gnt), int'(em));
    chk("h_gnt", int'(bus.h_gnt), int'(eh));
    chk("busy", int'(bus.busy), int'(busy_e));
    chk("state_dbg", int'(state_dbg), int'(busy_e));

    exp_mv = em && !bus.m_we;
    exp_hv = eh && !bus.h_we;
    if (exp_mv) m_exp_q.push_back(model_mem[{bus.m_y, bus.m_x}]);
    if (exp_hv) h_exp_q.push_back(model_mem[{bus.h_y, bus.h_x}]);
    if (em && bus.m_we) model_mem[{bus.m_y, bus.m_x}] = bus.m_wdata;
    if (eh && bus.h_we) model_mem[{bus.h_y, bus.h_x}] = bus.h_wdata;

    if (em) last_host = 1'b0;
    if (eh) last_host = 1'b1;
    if (!bus.h_lock || em) burst = 0;
    else if (eh && bus.m_req) burst = (burst < MAX_BURST) ? burst + 1 : MAX_BURST;

    if (clear_pos >= 0) begin
      model_mem[clear_pos] = CLR_VALUE;
      clear_pos++;
      if (clear_pos == DEPTH) clear_pos = -1;
    end else if (bus.clr) begin
      clear_pos = 0;
    end

    @(posedge CLK);
    #1;
    chk("m_valid", int'(bus.m_valid), int'(exp_mv));
    chk("h_valid", int'(bus.h_valid), int'(exp_hv));
    if (exp_mv && m_exp_q.size() > 0) chk("m_rdata", int'(bus.m_rdata), int'(m_exp_q.pop_front()));
    if (exp_hv && h_exp_q.size() > 0) chk("h_rdata", int'(bus.h_rdata), int'(h_exp_q.pop_front()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_m(input bit req, input bit we, input int x, input int y, input bit wd);
    bus.m_req   = req;
    bus.m_we    = we;
    bus.m_x     = 4'(x);
    bus.m_y     = 4'(y);
    bus.m_wdata = wd;
  endtask

  task automatic set_h(input bit req, input bit we, input int x, input int y, input bit wd,
                       input bit lock);
    bus.h_req   = req;
    bus.h_we    = we;
    bus.h_x     = 4'(x);
    bus.h_y     = 4'(y);
    bus.h_wdata = wd;
    bus.h_lock  = lock;
  endtask

  task automatic host_write(input int x, input int y, input bit wd);
    set_h(1'b1, 1'b1, x, y, wd, 1'b0);
    tick();
    set_h(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RST     = 1'b1;
    bus.clr = 1'b0;
    set_m(1'b1, 1'b0, 0, 0, 1'b0);
    set_h(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("rst_m_gnt", int'(bus.m_gnt), 0);
    chk("rst_h_gnt", int'(bus.h_gnt), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    set_m(1'b0, 1'b0, 0, 0, 1'b0);
    set_h(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    model_reset();
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_state", int'(state_dbg), 0);
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_h_valid", int'(bus.h_valid), 0);
    chk("rst_m_rdata", int'(bus.m_rdata), 0);
    chk("rst_h_rdata", int'(bus.h_rdata), 0);
    chk("rst_idle_m_gnt", int'(bus.m_gnt), 0);
    chk("rst_idle_h_gnt", int'(bus.h_gnt), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit m_req; bit m_we; int m_x; int m_y; bit m_wd;
    bit h_req; bit h_we; int h_x; int h_y; bit h_wd; bit h_lock;
    bit e_m; bit e_h; bit chk_nx; bit e_mrd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(bit mr, bit mw, int mx, int my, bit md,
                               bit hr, bit hw, int hx, int hy, bit hd, bit hl,
                               bit em, bit eh, bit cn, bit erd);
    vec_t v;
    v.m_req = mr; v.m_we = mw; v.m_x = mx; v.m_y = my; v.m_wd = md;
    v.h_req = hr; v.h_we = hw; v.h_x = hx; v.h_y = hy; v.h_wd = hd; v.h_lock = hl;
    v.e_m = em; v.e_h = eh; v.chk_nx = cn; v.e_mrd = erd;
    return v;
  endfunction

  initial begin
    int busy_cnt;
    int cyc;
    string hl_pat;
    RST = 1'b1;
    bus.clr = 1'b0;
    set_m(1'b0, 1'b0, 0, 0, 1'b0);
    set_h(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 1'b0;
    model_reset();

    // Alternation from reset: mouse wins the first tie.
    for (int i = 0; i < 6; i++)
      vecs.push_back(mkv(1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, (i % 2) == 0, (i % 2) == 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 1, 3, 5, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(1, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 1, 15, 15, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 1, 15, 15, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(1, 0, 15, 15, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Locked contention: H,H,H,H,M,H,H,H,H,M.
    hl_pat = "HHHHMHHHHM";
    for (int i = 0; i < 10; i++)
      vecs.push_back(mkv(1, 0, 15, 15, 0, 1, 0, 3, 5, 0, 1,
                         hl_pat[i] == "M", hl_pat[i] == "H", 0, 0));
    // Lock without contention is unbounded.
    for (int i = 0; i < 10; i++)
      vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 0, 3, 5, 0, 1, 0, 1, 0, 0));

    do_reset();

    // Bring the map to a known state with a full clear.
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    repeat (DEPTH) tick();
    chk("init_clear_done", int'(bus.busy), 0);
    do_reset();

    foreach (vecs[i]) begin
      set_m(vecs[i].m_req, vecs[i].m_we, vecs[i].m_x, vecs[i].m_y, vecs[i].m_wd);
      set_h(vecs[i].h_req, vecs[i].h_we, vecs[i].h_x, vecs[i].h_y, vecs[i].h_wd, vecs[i].h_lock);
      tick();
      chk($sformatf("vec%0d_m_gnt", i), int'(g_m), int'(vecs[i].e_m));
      chk($sformatf("vec%0d_h_gnt", i), int'(g_h), int'(vecs[i].e_h));
      if (vecs[i].chk_nx) begin
        chk($sformatf("vec%0d_m_valid", i), int'(bus.m_valid), 1);
        chk($sformatf("vec%0d_m_rdata", i), int'(bus.m_rdata), int'(vecs[i].e_mrd));
      end
    end
    set_m(1'b0, 1'b0, 0, 0, 1'b0);
    set_h(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Clear with a pending mouse read.
    host_write(0, 0, 1'b1);
    host_write(15, 15, 1'b1);
    host_write(2, 0, 1'b1);
    host_write(8, 12, 1'b1);
    bus.clr = 1'b1;
    set_m(1'b1, 1'b0, 0, 0, 1'b0);
    tick();
    chk("clr_cycle_no_gnt", int'(g_m), 0);
    bus.clr = 1'b0;
    busy_cnt = 0;
    cyc = 0;
    do begin
      tick();
      if (g_busy) busy_cnt++;
      cyc++;
    end while (!g_m && cyc < 400);
    chk("clear_busy_cycles", busy_cnt, DEPTH);
    chk("pending_gnt_first_arb", int'(g_m), 1);
    chk("first_arb_busy", int'(g_busy), 0);
    chk("clear_read_0_0", int'(bus.m_rdata), 0);
    set_m(1'b0, 1'b0, 0, 0, 1'b0);
    set_h(1'b1, 1'b0, 15, 15, 1'b0, 1'b0);
    tick();
    chk("clear_read_15_15_valid", int'(bus.h_valid), 1);
    chk("clear_read_15_15", int'(bus.h_rdata), 0);
    set_h(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Reset ten cycles into a clear.
    host_write(2, 0, 1'b1);
    host_write(8, 12, 1'b1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    repeat (10) tick();
    chk("mid_clear_busy", int'(bus.busy), 1);
    do_reset();
    set_h(1'b1, 1'b0, 2, 0, 1'b0, 1'b0);
    tick();
    chk("abort_addr2", int'(bus.h_rdata), 0);
    set_h(1'b1, 1'b0, 8, 12, 1'b0, 1'b0);
    tick();
    chk("abort_addr200", int'(bus.h_rdata), 1);
    set_h(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Randomized traffic with held requests, lock toggling and occasional clears.
    g_m = 1'b0;
    g_h = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.m_req || g_m)
        set_m($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if (!bus.h_req || g_h) begin
        bus.h_req   = $urandom_range(0, 3) != 0;
        bus.h_we    = 1'($urandom_range(0, 1));
        bus.h_x     = 4'($urandom_range(0, 3));
        bus.h_y     = 4'($urandom_range(0, 3));
        bus.h_wdata = 1'($urandom_range(0, 1));
      end
      bus.h_lock = (c < 1500) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) != 0);
      bus.clr    = ($urandom_range(0, 599) == 0);
      tick();
    end
    bus.clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
